// File: rtl/code_conv_seq.sv
// code_conv_seq: handshaked W-bit code converter.
// Gray encode/decode finish in a single cycle. BCD and Excess-3 use an
// iterative double-dabble engine that consumes one source bit per cycle.
// Handshake: a word transfers in when in_valid && in_ready at a rising edge,
// and a result transfers out when out_valid && out_ready. While out_valid is
// high and out_ready is low, dout and out_valid hold steady. in_ready is also
// high in DONE when out_ready is high, so a new word can be accepted on the
// same edge that consumes the previous result.
module code_conv_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          din,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;      // BCD field width
  localparam int SW = BW + W;          // double-dabble register width
  localparam int CW = $clog2(W + 1);   // bit counter width

  // Parameter sanity: the BCD field must hold the largest W-bit value.
  if (W < 2) begin : g_bad_width
    $error("code_conv_seq: W must be >= 2");
  end
  if ((10 ** DIGITS) <= ((2 ** W) - 1)) begin : g_bad_digits
    $error("code_conv_seq: DIGITS too small for W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   count_q, count_d;
  logic            xs3_q,   xs3_d;
  logic [BW-1:0]   dout_q,  dout_d;

  logic            in_xfer;
  logic [W-1:0]    gray_enc;
  logic [W-1:0]    gray_dec;
  logic [SW-1:0]   adjusted;
  logic [SW-1:0]   shifted;
  logic [BW-1:0]   bcd_final;
  logic [BW-1:0]   xs3_final;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CONV);
  assign dout      = dout_q;

  // Single-cycle Gray encode and prefix-XOR Gray decode of the incoming word.
  always_comb begin
    gray_enc = din ^ (din >> 1);
    gray_dec = '0;
    gray_dec[W-1] = din[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      gray_dec[i] = gray_dec[i+1] ^ din[i];
    end
  end

  // One double-dabble step: add 3 to each BCD digit >= 5, then shift left.
  // Also forms the final BCD / Excess-3 words from the last shifted value.
  always_comb begin
    adjusted = shift_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (shift_q[W + 4*d +: 4] >= 4'd5) begin
        adjusted[W + 4*d +: 4] = shift_q[W + 4*d +: 4] + 4'd3;
      end
    end
    shifted   = adjusted << 1;
    bcd_final = shifted[SW-1:W];
    xs3_final = '0;
    for (int d = 0; d < DIGITS; d++) begin
      // Per-digit add with no carry into the neighbouring digit.
      xs3_final[4*d +: 4] = bcd_final[4*d +: 4] + 4'd3;
    end
  end

  // Next-state and datapath control for IDLE / CONV / DONE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    xs3_d   = xs3_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_xfer) begin
          if (!mode[1]) begin
            // Gray modes: result is ready at the accept edge.
            state_d = S_DONE;
            dout_d  = mode[0] ? BW'(gray_dec) : BW'(gray_enc);
          end else begin
            // BCD / XS3: load {BCD=0, din}, run W shift steps.
            state_d = S_CONV;
            shift_d = {{BW{1'b0}}, din};
            count_d = CW'(W);
            xs3_d   = mode[0];
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        shift_d = shifted;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          dout_d  = xs3_q ? xs3_final : bcd_final;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      count_q <= '0;
      xs3_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      xs3_q   <= xs3_d;
      dout_q  <= dout_d;
    end
  end

endmodule
